// File: rtl/tlb_refill_walker_pkg.sv
// Shared definitions for the two-level page-table walker, the TLB and the exception unit:
// walker state encoding, PTE field positions and default fault codes.
package tlb_refill_walker_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_WAIT = 3'd2,
    L2_REQ  = 3'd3,
    L2_WAIT = 3'd4,
    FILL    = 3'd5,
    DONE    = 3'd6,
    DRAIN   = 3'd7
  } walk_state_e;

  localparam int PTE_VALID    = 0;
  localparam int PTE_USER     = 1;
  localparam int PTE_FRAME_HI = 17;
  localparam int PTE_FRAME_LO = 12;

  localparam logic [7:0] EXC_UFAULT_DEFAULT = 8'h84;
  localparam logic [7:0] EXC_KFAULT_DEFAULT = 8'h85;

  function automatic logic [7:0] fault_code(input logic kmode, input logic [7:0] ucode,
                                            input logic [7:0] kcode);
    return kmode ? kcode : ucode;
  endfunction

endpackage

// File: rtl/tlb_refill_walker.sv
// Two-level page-table walker: on a TLB miss reads the L1 and L2 PTEs, then either
// fills the TLB or reports a page fault. Handshakes: a transfer happens when valid && ready.
module tlb_refill_walker
  import tlb_refill_walker_pkg::*;
#(
  parameter logic [7:0] EXC_UFAULT = EXC_UFAULT_DEFAULT,
  parameter logic [7:0] EXC_KFAULT = EXC_KFAULT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_pid,
  input  logic [31:0] req_vaddr,
  input  logic        req_kmode,
  input  logic [31:0] ptbr,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        tlb_we,
  output logic [31:0] tlb_key,
  output logic [31:0] tlb_data,
  output logic        done_valid,
  output logic [7:0]  done_exc,
  input  logic        flush,
  output walk_state_e state_dbg
);

  walk_state_e state;
  logic [11:0] pid_q;
  logic [19:0] vpn_q;
  logic        kmode_q;
  logic        tlb_we_q;
  logic        done_q;
  logic        l2_fault;
  logic        unused_bits;

  assign l2_fault    = !mem_resp_data[PTE_VALID] || (!kmode_q && !mem_resp_data[PTE_USER]);
  assign unused_bits = ^{ptbr[11:0], req_vaddr[11:0], mem_resp_data[11:2]};
  assign state_dbg   = state;

  // A flush in FILL or DONE must suppress the pulse of that very cycle.
  assign tlb_we     = tlb_we_q && !flush;
  assign done_valid = done_q && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      tlb_we_q      <= 1'b0;
      tlb_key       <= '0;
      tlb_data      <= '0;
      done_q        <= 1'b0;
      done_exc      <= '0;
      pid_q         <= '0;
      vpn_q         <= '0;
      kmode_q       <= 1'b0;
    end else begin
      tlb_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready && !flush) begin
            pid_q         <= req_pid;
            vpn_q         <= req_vaddr[31:12];
            kmode_q       <= req_kmode;
            mem_addr      <= {ptbr[31:12], req_vaddr[31:22], 2'b00};
            mem_req_valid <= 1'b1;
            req_ready     <= 1'b0;
            state         <= L1_REQ;
          end
        end
        L1_REQ, L2_REQ: begin
          if (flush) begin
            mem_req_valid <= 1'b0;
            req_ready     <= 1'b1;
            state         <= IDLE;
          end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (state == L1_REQ) state <= L1_WAIT;
            else                 state <= L2_WAIT;
          end
        end
        L1_WAIT, L2_WAIT: begin
          if (flush) begin
            // A response landing with the flush is the one we would have drained.
            if (mem_resp_valid) begin
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (mem_resp_valid) begin
            if ((state == L1_WAIT && !mem_resp_data[PTE_VALID]) ||
                (state == L2_WAIT && l2_fault)) begin
              done_q   <= 1'b1;
              done_exc <= fault_code(kmode_q, EXC_UFAULT, EXC_KFAULT);
              state    <= DONE;
            end else if (state == L1_WAIT) begin
              mem_addr      <= {mem_resp_data[31:12], vpn_q[9:0], 2'b00};
              mem_req_valid <= 1'b1;
              state         <= L2_REQ;
            end else begin
              tlb_key  <= {pid_q, vpn_q};
              tlb_data <= {26'd0, mem_resp_data[PTE_FRAME_HI:PTE_FRAME_LO]};
              tlb_we_q <= 1'b1;
              state    <= FILL;
            end
          end
        end
        FILL: begin
          if (flush) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            done_q   <= 1'b1;
            done_exc <= 8'd0;
            state    <= DONE;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        DRAIN: begin
          if (mem_resp_valid) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
